// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage for the 16-bit ALU.
// It holds an 8-entry register file with one synchronous write port.
// On start it reads R[rn] into the A operand, then the shifted R[rm] into
// the B operand, and pulses valid for one cycle when both are loaded.
module alu_operand_fetch #(
  parameter int k = 16,
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write,
  input  logic [n-1:0] waddr,
  input  logic [k-1:0] wdata,
  input  logic         start,
  input  logic [n-1:0] rn,
  input  logic [n-1:0] rm,
  input  logic [1:0]   shift,
  input  logic         asel,
  output logic         busy,
  output logic         valid,
  output logic [k-1:0] ain,
  output logic [k-1:0] bin
);

  localparam int DEPTH = 1 << n;

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, DONE} state_t;

  state_t       state_q, state_d;
  logic [k-1:0] regs_q [DEPTH];
  logic [n-1:0] rn_q, rm_q;
  logic [1:0]   shift_q;
  logic         asel_q;
  logic [k-1:0] ain_q, ain_d;
  logic [k-1:0] bin_q, bin_d;
  logic         accept;
  logic [k-1:0] rm_data;
  logic [k-1:0] shifted;

  // Register file: a write lands on the edge; reads see only stored contents.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs
      // Each entry clears on reset and otherwise captures a write to its address.
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else if (write && (waddr == n'(gi))) begin
          regs_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  // A new fetch can only begin from IDLE or DONE; start elsewhere is dropped.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // Shift the B source by one bit, keeping the width unchanged.
  always_comb begin
    rm_data = regs_q[rm_q];
    shifted = rm_data;
    unique case (shift_q)
      2'b00: shifted = rm_data;
      2'b01: shifted = {rm_data[k-2:0], 1'b0};
      2'b10: shifted = {1'b0, rm_data[k-1:1]};
      2'b11: shifted = {rm_data[k-1], rm_data[k-1:1]};
      default: shifted = rm_data;
    endcase
  end

  // Next-state and operand-load logic; the operands hold unless their READ state is active.
  always_comb begin
    state_d = state_q;
    ain_d   = ain_q;
    bin_d   = bin_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ_A;
      READ_A: begin
        ain_d   = asel_q ? '0 : regs_q[rn_q];
        state_d = READ_B;
      end
      READ_B: begin
        bin_d   = shifted;
        state_d = DONE;
      end
      DONE:    state_d = start ? READ_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers; reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ain_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ain_q   <= ain_d;
      bin_q   <= bin_d;
    end
  end

  // Latch the command when a fetch is accepted so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= 2'b00;
      asel_q  <= 1'b0;
    end else if (accept) begin
      rn_q    <= rn;
      rm_q    <= rm;
      shift_q <= shift;
      asel_q  <= asel;
    end
  end

  assign busy  = (state_q == READ_A) || (state_q == READ_B);
  assign valid = (state_q == DONE);
  assign ain   = ain_q;
  assign bin   = bin_q;

endmodule
